// File: rtl/dog_frame_ctrl.sv
// -----------------------------------------------------------------------------
// dog_frame_ctrl
//
// Frame-level sequencer for the DoG read path. Tracks two ping-pong input
// frame banks filled by the pixel loader. Each full bank is handed to the DoG
// read address generator with a one-cycle start pulse. The controller follows
// the row pass (ram0 valid) and the column pass (ram1 valid) to completion,
// waits for the downstream pipeline to drain, and then releases the bank back
// to the loader. Frame status and sticky errors are reported to the host.
//
// Parameters
//   DRAIN_CYCLES  cycles spent in DRAIN after the column pass ends (>= 1)
//   TIMEOUT       max cycles from rd_start to the end of the column pass (>= 2)
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   load_done      in   pulse: bank wr_bank has been filled by the loader
//   rd_ram0_valid  in   row-pass read valid from the address generator
//   rd_ram1_valid  in   column-pass read valid from the address generator
//   err_clr        in   pulse: clear both sticky errors
//   wr_bank        out  bank the loader writes next
//   wr_ready       out  bank wr_bank is empty (combinational)
//   rd_bank        out  bank the address generator reads (RAM bank mux select)
//   rd_start       out  one-cycle start pulse to the address generator
//   busy           out  high in every state except IDLE
//   pass_phase     out  0 idle/start, 1 row pass, 2 column pass, 3 drain/done
//   frame_done     out  one-cycle pulse when a frame completes
//   frame_cnt      out  completed frame count, wraps
//   err_overrun    out  sticky: load_done arrived while wr_ready was low
//   err_timeout    out  sticky: a frame exceeded TIMEOUT
// -----------------------------------------------------------------------------
module dog_frame_ctrl #(
   parameter int DRAIN_CYCLES = 4,
   parameter int TIMEOUT      = 140000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_done,
   input  logic        rd_ram0_valid,
   input  logic        rd_ram1_valid,
   input  logic        err_clr,
   output logic        wr_bank,
   output logic        wr_ready,
   output logic        rd_bank,
   output logic        rd_start,
   output logic        busy,
   output logic [1:0]  pass_phase,
   output logic        frame_done,
   output logic [15:0] frame_cnt,
   output logic        err_overrun,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN_H,
      S_RUN_V,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int            DW           = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LAST   = DW'(DRAIN_CYCLES - 1);
   localparam logic [17:0]   CYC_MAX      = '1;
   // cyc_cnt is cleared at the end of START, so in the k-th cycle after
   // rd_start it holds k-1. Leaving RUN when it holds TIMEOUT-2 lands the
   // DONE cycle exactly TIMEOUT cycles after rd_start.
   localparam logic [17:0]   TIMEOUT_LAST = 18'(TIMEOUT - 2);

   state_t         state, next_state;
   logic [1:0]     full;
   logic [1:0]     full_set, full_clr;
   logic           ram0_q, ram1_q;
   logic           ram0_fall, ram1_fall;
   logic [17:0]    cyc_cnt;
   logic [DW-1:0]  drain_cnt;
   logic [15:0]    frame_cnt_q;
   logic           load_ok, load_bad;
   logic           in_run;
   logic           timeout_hit;

   // Next-cycle values of the registered status outputs.
   logic           rd_start_d;
   logic           busy_d;
   logic [1:0]     pass_phase_d;
   logic           frame_done_d;

   // ---------------------------------------------------------------------------
   // Bank bookkeeping and edge detection (combinational)
   // ---------------------------------------------------------------------------
   assign wr_ready  = ~full[wr_bank];
   assign load_ok   = load_done &  wr_ready;
   assign load_bad  = load_done & ~wr_ready;

   assign ram0_fall = ram0_q & ~rd_ram0_valid;
   assign ram1_fall = ram1_q & ~rd_ram1_valid;

   assign in_run      = (state == S_RUN_H) || (state == S_RUN_V);
   assign timeout_hit = in_run && (cyc_cnt >= TIMEOUT_LAST);

   // A set and a clear never target the same bit (a full bank is never the
   // write target), so the two masks are applied independently.
   assign full_set = load_ok          ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign full_clr = (state == S_DONE) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

   assign frame_cnt = frame_cnt_q;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // sample the same pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top of each always_comb keeps every
   // path assigned, so no latch is inferred when a case arm does not write it.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:  if (full[rd_bank]) next_state = S_START;
         S_START: next_state = S_RUN_H;
         S_RUN_H: begin
            if (timeout_hit)    next_state = S_DONE;
            else if (ram0_fall) next_state = S_RUN_V;
         end
         S_RUN_V: begin
            if (timeout_hit)    next_state = S_DONE;
            else if (ram1_fall) next_state = S_DRAIN;
         end
         S_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // Decoded from next_state and registered below, so each output is a clean
   // flop that is valid during the cycle the FSM spends in the matching state.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_start_d   = 1'b0;
      busy_d       = 1'b1;
      pass_phase_d = 2'd0;
      frame_done_d = 1'b0;
      unique case (next_state)
         S_IDLE:  busy_d       = 1'b0;
         S_START: rd_start_d   = 1'b1;
         S_RUN_H: pass_phase_d = 2'd1;
         S_RUN_V: pass_phase_d = 2'd2;
         S_DRAIN: pass_phase_d = 2'd3;
         S_DONE: begin
            pass_phase_d = 2'd3;
            frame_done_d = 1'b1;
         end
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_start   <= 1'b0;
         busy       <= 1'b0;
         pass_phase <= 2'd0;
         frame_done <= 1'b0;
      end else begin
         rd_start   <= rd_start_d;
         busy       <= busy_d;
         pass_phase <= pass_phase_d;
         frame_done <= frame_done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Banks, counters, edge-detect flops
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full        <= 2'b00;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         ram0_q      <= 1'b0;
         ram1_q      <= 1'b0;
         cyc_cnt     <= '0;
         drain_cnt   <= '0;
         frame_cnt_q <= 16'd0;
      end else begin
         ram0_q <= rd_ram0_valid;
         ram1_q <= rd_ram1_valid;

         full <= (full & ~full_clr) | full_set;
         if (load_ok) begin
            wr_bank <= ~wr_bank;
         end

         if (state == S_DONE) begin
            rd_bank     <= ~rd_bank;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end

         // Frame watchdog: saturates so a stuck pass cannot wrap it back
         // below the limit.
         if (state == S_START) begin
            cyc_cnt <= '0;
         end else if (in_run && (cyc_cnt != CYC_MAX)) begin
            cyc_cnt <= cyc_cnt + 18'd1;
         end

         if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky errors: a new error event in the same cycle as err_clr wins.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (load_bad)     err_overrun <= 1'b1;
         else if (err_clr) err_overrun <= 1'b0;

         if (timeout_hit)  err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

endmodule

// File: doc/dog_frame_ctrl.md
# dog_frame_ctrl

Frame-level sequencer for the DoG read path. It tracks two ping-pong input frame banks filled by the pixel loader, and launches the DoG read address generator on each full bank with a one-cycle start pulse. It follows the generator's row pass (ram0 valid) and column pass (ram1/ram2 valid) to completion, then releases the bank to the loader and reports frame status and errors to the host.

## Interface
- DRAIN_CYCLES, 4: cycles waited after the column pass ends before the bank is released (downstream pipeline flush).
- TIMEOUT, 140000: maximum cycles from rd_start to end of column pass. A nominal run is 262 x 512 = 134144 cycles.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_done  in  1  one-cycle pulse from the loader: bank wr_bank is now filled.
- rd_ram0_valid  in  1  row-pass read valid from the address generator.
- rd_ram1_valid  in  1  column-pass read valid from the address generator.
- err_clr  in  1  one-cycle pulse that clears the sticky errors.
- wr_bank  out  1  bank the loader writes next.
- wr_ready  out  1  1 when bank wr_bank is empty; the loader may write only while it is high.
- rd_bank  out  1  bank the address generator reads; drives the RAM bank mux.
- rd_start  out  1  one-cycle start pulse to the address generator.
- busy  out  1  1 in every state except IDLE.
- pass_phase  out  2  0 idle/start, 1 row pass, 2 column pass, 3 drain/done.
- frame_done  out  1  one-cycle pulse when a frame completes (normal or timeout).
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0.
- err_overrun  out  1  sticky: load_done arrived while wr_ready = 0.
- err_timeout  out  1  sticky: a frame exceeded TIMEOUT.

## Operation
- **Bank state.** full[1:0] is all zeros after reset. wr_ready = ~full[wr_bank] (combinational).
- **Load, accepted.** load_done with wr_ready = 1 sets full[wr_bank] and toggles wr_bank.
- **Load, rejected.** load_done with wr_ready = 0 sets err_overrun. full and wr_bank are unchanged.
- **Bank release.** The DONE state clears full[rd_bank] and toggles rd_bank.
- **Same-cycle set and clear.** A set and a clear in the same cycle act independently per bit. A set and a clear on the same bit cannot happen, because a full bank is never the write target.
- **Edge detect.** One registered copy of each valid input. "fall" = previous 1 and current 0.
- **FSM states:** IDLE, START, RUN_H, RUN_V, DRAIN, DONE.
  - IDLE: if full[rd_bank], go to START.
  - START: rd_start = 1 for this cycle only; clear the cycle counter; go to RUN_H.
  - RUN_H: on rd_ram0_valid fall, go to RUN_V.
  - RUN_V: on rd_ram1_valid fall, go to DRAIN.
  - DRAIN: count DRAIN_CYCLES cycles, then go to DONE.
  - DONE: frame_done = 1; frame_cnt + 1; release the bank; go to IDLE.
- **Timeout.** The cycle counter (18 bits, saturating) runs in RUN_H and RUN_V. When it reaches TIMEOUT: set err_timeout and go directly to DONE (the bank is still released and frame_cnt still increments).
- **Error clear.** err_clr clears both sticky errors. If an error event occurs in the same cycle, the error stays set (set wins).
- **Reset mid-frame.** Everything returns to its reset value immediately; any partial frame is abandoned.

## Timing
- **Reset values:** wr_bank 0, wr_ready 1, rd_bank 0, rd_start 0, busy 0, pass_phase 0, frame_done 0, frame_cnt 0, both errors 0, state IDLE.
- **Start latency.** load_done at cycle t (bank empty, FSM idle): full set at t+1, START at t+2, rd_start high during t+2 only.
- **Back-to-back frames.** If the other bank is already full when DONE is reached, the next rd_start comes exactly 2 cycles after frame_done.
- **Drain latency.** Fall of rd_ram1_valid sampled at cycle c: DRAIN occupies c+1 .. c+DRAIN_CYCLES, frame_done at c+DRAIN_CYCLES+1.
- All outputs are registered except wr_ready.

## Test plan
- **Single frame.** load_done at cycle 10; generator stub drives ram0 valid high 134144/2 cycles, then ram1 valid for the rest -> rd_start at cycle 12, rd_bank = 0. frame_done at DRAIN_CYCLES + 1 after ram1 fall; then frame_cnt = 1, rd_bank = 1, wr_ready = 1.
- **Ping-pong.** Two load_done pulses 5 cycles apart -> wr_bank 0 -> 1 -> 0 and wr_ready = 0 after the second. The second frame's rd_start comes 2 cycles after the first frame_done with rd_bank = 1; frame_cnt = 2 at the end.
- **Overrun.** A third load_done while both banks are full -> err_overrun = 1; full and frame_cnt unaffected. err_clr -> err_overrun = 0 the next cycle. err_clr in the same cycle as an overrun -> err_overrun stays 1.
- **Timeout.** Stub holds ram0 valid high forever -> err_timeout = 1 and frame_done exactly TIMEOUT cycles after rd_start. Bank released, FSM in IDLE, frame_cnt = 1.
- **Reset mid-pass.** rst_n low for 3 cycles during RUN_V -> all outputs at reset values while low. After release: no rd_start until a new load_done; the next frame completes normally with frame_cnt = 1.
- **Counter wrap.** Force frame_cnt = 0xFFFF, complete one frame -> frame_cnt = 0x0000, no error flags set.
